vga_frame_scheduler: RTL and testbench
======================================

Name: vga_frame_scheduler

Overview:
- Sequences per-frame game-logic updates (Mario, enemies, scroll, score) so every object-state write lands during vertical blanking, never while the VGA timing core is fetching pixels.
- Watches the VGA timing core's `vs` and `rdn` (active-video read strobe, active-low).
- Issues one-at-a-time request/done handshakes to up to N update clients in fixed index order.
- Flags an overrun if work is still pending when active video resumes.

Parameters:
- N_CLIENTS, 4, number of update clients (1..8)
- TIMEOUT, 1023, max cycles to wait for one client's done before abandoning it
- FCNT_W, 16, width of frame counter

Ports:
- clk  in  1  pixel clock, same clock as the VGA timing core
- rst  in  1  synchronous, active-high reset
- vs  in  1  vertical sync from timing core, active-low pulse
- rdn  in  1  active-video strobe from timing core; 0 = pixel being displayed
- en_mask  in  N_CLIENTS  per-client enable; sampled at frame start
- upd_done  in  N_CLIENTS  client i pulses/holds bit i when its update is complete
- ovr_clr  in  1  clears the sticky overrun flag
- upd_req  out  N_CLIENTS  one-hot (or zero) request to client i
- frame_tick  out  1  one-cycle pulse at start of each vblank
- busy  out  1  high while a sequence is in progress
- overrun  out  1  sticky: sequence unfinished when rdn went low, or a client timed out
- timeout_id  out  3  index of the last client that timed out
- frame_cnt  out  FCNT_W  frames seen since reset; wraps

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Edge detection:
  - vs_q registers vs.
  - Frame start = vs_q==1 && vs==0 (falling edge of vs).
- State IDLE:
  - On frame start: frame_tick=1 for exactly that cycle; frame_cnt+1 with wrap (all-ones -> 0).
  - Latch en_mask into pend.
  - If pend==0 stay IDLE (busy stays 0); else go to SCAN with idx=0.
- State SCAN:
  - Find the lowest set bit in pend at or above idx.
  - If found: set idx, go to WAIT, assert upd_req[idx] from the next cycle.
  - If none: go to IDLE, busy=0.
  - Takes one cycle.
- State WAIT:
  - Hold upd_req[idx]=1 and clear the wait counter on entry.
  - upd_done[idx]==1: drop upd_req in the same registered update (low next cycle), clear pend[idx], go to SCAN.
  - Wait counter reaches TIMEOUT with no done: drop the request, overrun=1, timeout_id=idx, clear pend[idx], go to SCAN.
  - upd_done bits other than idx are ignored.
- busy=1 in SCAN and WAIT.
- upd_req is registered, never more than one bit high, and 0 outside WAIT.
- Overrun on active video:
  - rdn==0 while busy: set overrun=1.
  - The sequence continues; no abort.
- Frame start while busy (sequence spans a whole frame):
  - frame_tick and frame_cnt still update.
  - overrun=1.
  - pend is OR-ed with en_mask; current WAIT continues.
- ovr_clr:
  - Clears overrun.
  - A set condition in the same cycle wins (overrun stays 1).
- rst asserted mid-sequence: next cycle all upd_req=0, state IDLE, pend=0.

Decomposition:
- Shared package vga_sched_pkg:
  - state enum (IDLE, SCAN, WAIT)
  - constant MAX_CLIENTS=8
  - function for the lowest-set-bit-at-or-above search
- One natural sub-module: sched_timeout_ctr (loadable down-counter with expiry flag), instantiated once.

Test Plan:
1. Reset, N=4, en_mask=4'b1011, drive a vs falling edge:
   - frame_tick pulses one cycle and frame_cnt=1.
   - upd_req sequence is 0001 -> 0010 -> 1000, each held until the matching done.
   - Bit 2 is never requested; busy drops after the final done.
2. en_mask=0 at frame start: frame_tick pulses; busy and upd_req stay 0.
3. Client 1 never asserts done, TIMEOUT=15:
   - upd_req[1] drops after 15 wait cycles.
   - overrun=1, timeout_id=1, and client 3 is requested next.
4. rdn driven low while waiting on client 0:
   - overrun=1 and the sequence still completes.
   - ovr_clr then returns overrun to 0; ovr_clr in the same cycle as rdn low leaves it 1.
5. Second vs edge while busy:
   - frame_cnt increments, overrun=1.
   - Newly enabled clients are serviced after the current one.
6. Assert rst while upd_req=0100: upd_req=0 and busy=0 the next cycle; frame_cnt=0.

Source files
------------

// File: rtl/vga_sched_pkg.sv
// vga_sched_pkg
// Shared types and helpers for the VGA frame scheduler.
//   state_t      : scheduler FSM states
//   MAX_CLIENTS  : upper bound on the number of update clients
//   next_client  : lowest set bit of a pending mask at or above a start index
package vga_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int MAX_CLIENTS = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Walks downward so the last hit kept is the lowest qualifying bit.
    function automatic pick_t next_client(input logic [MAX_CLIENTS-1:0] pend,
                                          input logic [2:0]             from);
        pick_t r;
        r = '0;
        for (int i = MAX_CLIENTS - 1; i >= 0; i--) begin
            if (pend[i] && (3'(i) >= from)) begin
                r.found = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_frame_scheduler_timeout_ctr.sv
// sched_timeout_ctr
// Loadable down-counter; expired is high while the count sits at zero.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (has priority over dec)
//   load_val  : value loaded on load
//   dec       : decrement by one, saturating at zero
//   expired   : count == 0
module sched_timeout_ctr
    import vga_sched_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler
// Sequences per-frame client updates into vertical blanking. A falling edge
// of vs starts a frame; enabled clients are requested one at a time in
// ascending index order, each until its done bit or a timeout.
//   clk, rst    : pixel clock, synchronous active-high reset
//   vs, rdn     : vertical sync (active low), active-video strobe (0 = pixel)
//   en_mask     : per-client enable, sampled at frame start
//   upd_done    : per-client completion
//   ovr_clr     : clears the sticky overrun flag
//   upd_req     : registered one-hot request
//   frame_tick  : one-cycle pulse per frame start
//   busy        : sequence in progress
//   overrun     : sticky; active video, new frame or timeout while busy
//   timeout_id  : last client that timed out
//   frame_cnt   : frames since reset, wrapping
//
// state | meaning
// IDLE  | waiting for a vs falling edge
// SCAN  | picking the next pending client at or above idx
// WAIT  | request held to client idx until done or timeout
module vga_frame_scheduler
    import vga_sched_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int TIMEOUT   = 1023,
    parameter int FCNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vs,
    input  logic                 rdn,
    input  logic [N_CLIENTS-1:0] en_mask,
    input  logic [N_CLIENTS-1:0] upd_done,
    input  logic                 ovr_clr,
    output logic [N_CLIENTS-1:0] upd_req,
    output logic                 frame_tick,
    output logic                 busy,
    output logic                 overrun,
    output logic [2:0]           timeout_id,
    output logic [FCNT_W-1:0]    frame_cnt
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Loaded on WAIT entry so the request stays high for exactly TIMEOUT cycles.
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

    state_t                 state, state_n;
    logic [2:0]             idx, idx_n;
    logic [N_CLIENTS-1:0]   pend, pend_n, pend_eff, oh, req_n;
    logic [MAX_CLIENTS-1:0] p8;
    logic                   vs_q, fs, done_hit, expired, ld, to_hit, ovr_set;
    pick_t                  pick;

    assign fs       = vs_q & ~vs;
    assign oh       = N_CLIENTS'(1) << idx;
    assign done_hit = |(upd_done & oh);
    assign pend_eff = fs ? (pend | en_mask) : pend;
    assign busy     = (state != IDLE);

    sched_timeout_ctr #(.W(CW)) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .load     (ld),
        .load_val (LOAD_VAL),
        .dec      (state == WAIT),
        .expired  (expired)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        pend_n  = pend;
        ld      = 1'b0;
        to_hit  = 1'b0;
        p8      = '0;
        p8[N_CLIENTS-1:0] = pend_eff;
        pick    = '0;
        case (state)
            IDLE: begin
                if (fs) begin
                    pend_n = en_mask;
                    if (|en_mask) begin
                        state_n = SCAN;
                        idx_n   = '0;
                    end
                end
            end
            SCAN: begin
                pick = next_client(p8, idx);
                if (pick.found) begin
                    state_n = WAIT;
                    idx_n   = pick.idx;
                    pend_n  = pend_eff;
                    ld      = 1'b1;
                end else if (fs && (|en_mask)) begin
                    // A frame began on the very cycle the scan ran dry:
                    // rescan from client 0 rather than drop that frame.
                    idx_n  = '0;
                    pend_n = pend_eff;
                end else begin
                    state_n = IDLE;
                    idx_n   = '0;
                    pend_n  = '0;
                end
            end
            WAIT: begin
                pend_n = pend_eff;
                if (done_hit || expired) begin
                    pend_n  = pend_eff & ~oh;
                    state_n = SCAN;
                    to_hit  = ~done_hit;
                end
            end
            default: state_n = IDLE;
        endcase
        ovr_set = to_hit || (busy && (!rdn || fs));
        req_n   = (state_n == WAIT) ? (N_CLIENTS'(1) << idx_n) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            pend       <= '0;
            vs_q       <= 1'b0;
            upd_req    <= '0;
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
            overrun    <= 1'b0;
            timeout_id <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            pend       <= pend_n;
            vs_q       <= vs;
            upd_req    <= req_n;
            frame_tick <= fs;
            if (fs) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
            if (to_hit) begin
                timeout_id <= idx;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// tb_vga_frame_scheduler
// Directed bench for vga_frame_scheduler (4 clients, TIMEOUT 15). A frame
// counter model and a request-order scoreboard are checked every cycle;
// directed literals pin handshake, overrun and reset behaviour.
module tb_vga_frame_scheduler;

    localparam int N  = 4;
    localparam int TO = 15;

    logic         clk = 1'b0;
    logic         rst, vs, rdn, ovr_clr;
    logic [N-1:0] en_mask, upd_done, upd_req;
    logic         frame_tick, busy, overrun;
    logic [2:0]   timeout_id;
    logic [15:0]  frame_cnt;

    always #5 clk = ~clk;

    vga_frame_scheduler #(.N_CLIENTS(N), .TIMEOUT(TO), .FCNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .vs         (vs),
        .rdn        (rdn),
        .en_mask    (en_mask),
        .upd_done   (upd_done),
        .ovr_clr    (ovr_clr),
        .upd_req    (upd_req),
        .frame_tick (frame_tick),
        .busy       (busy),
        .overrun    (overrun),
        .timeout_id (timeout_id),
        .frame_cnt  (frame_cnt)
    );

    // Frame model: a frame begins wherever vs was high on one rising edge
    // and low on the next; the tick and count show up after that edge.
    logic        m_vsq  = 1'b0;
    logic        m_tick = 1'b0;
    logic [15:0] m_cnt  = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_vsq  = 1'b0;
            m_tick = 1'b0;
            m_cnt  = '0;
        end else begin
            m_tick = m_vsq && !vs;
            if (m_tick) m_cnt = m_cnt + 16'd1;
            m_vsq = vs;
        end
    end

    int           vectors    = 0;
    int           miscompares = 0;
    int           exp_order[$];
    logic [N-1:0] prev_req = '0;
    int           lat [N];
    int           rcnt[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: advance to the falling edge, compare, then run the clients.
    task automatic tick();
        int e;
        @(negedge clk);
        chk("frame_tick_model", 32'(frame_tick), 32'(m_tick));
        chk("frame_cnt_model", 32'(frame_cnt), 32'(m_cnt));
        chk("req_onehot0", 32'($onehot0(upd_req)), 1);
        chk("req_zero_when_idle", 32'(busy || (upd_req == '0)), 1);
        if ((upd_req != '0) && (upd_req != prev_req)) begin
            if (exp_order.size() == 0) begin
                chk("req_unexpected", 32'(upd_req), 0);
            end else begin
                e = exp_order.pop_front();
                chk("req_order", 32'(upd_req), 32'(1) << e);
            end
        end
        prev_req = upd_req;
        for (int i = 0; i < N; i++) begin
            if (upd_req[i]) begin
                rcnt[i]++;
                if ((lat[i] != 0) && (rcnt[i] >= lat[i])) upd_done[i] = 1'b1;
            end else begin
                rcnt[i]     = 0;
                upd_done[i] = 1'b0;
            end
        end
    endtask

    task automatic pulse_vs();
        vs = 1'b0;
        tick();
        vs = 1'b1;
    endtask

    task automatic wait_req(input int i);
        int n;
        n = 0;
        while (!upd_req[i] && n < 100) begin
            tick();
            n++;
        end
        if (!upd_req[i]) chk("wait_req_bound", 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        if (busy) chk("wait_idle_bound", 0, 1);
    endtask

    task automatic clear_ovr();
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; vs = 1'b1; rdn = 1'b1; ovr_clr = 1'b0;
        en_mask = '0; upd_done = '0;
        for (int i = 0; i < N; i++) begin lat[i] = 2; rcnt[i] = 0; end
        repeat (3) tick();
        chk("rst_upd_req", 32'(upd_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_timeout_id", 32'(timeout_id), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_frame_tick", 32'(frame_tick), 0);
        rst = 1'b0;
        repeat (2) tick();

        // 1: mask 1011 -> clients 0, 1, 3
        en_mask = 4'b1011;
        exp_order.push_back(0); exp_order.push_back(1); exp_order.push_back(3);
        pulse_vs();
        chk("t1_tick", 32'(frame_tick), 1);
        chk("t1_cnt", 32'(frame_cnt), 1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_req_scan", 32'(upd_req), 0);
        tick();
        chk("t1_tick_one_cycle", 32'(frame_tick), 0);
        chk("t1_req0", 32'(upd_req), 32'h1);
        tick();
        chk("t1_req0_held", 32'(upd_req), 32'h1);
        wait_idle();
        chk("t1_all_served", 32'(exp_order.size()), 0);
        chk("t1_req_end", 32'(upd_req), 0);
        chk("t1_overrun", 32'(overrun), 0);

        // 2: empty mask
        en_mask = 4'b0000;
        pulse_vs();
        chk("t2_tick", 32'(frame_tick), 1);
        chk("t2_cnt", 32'(frame_cnt), 2);
        for (int k = 0; k < 4; k++) begin
            chk("t2_busy", 32'(busy), 0);
            chk("t2_req", 32'(upd_req), 0);
            tick();
        end

        // 3: client 1 never answers
        en_mask = 4'b1011; lat[1] = 0;
        exp_order.push_back(0); exp_order.push_back(1); exp_order.push_back(3);
        pulse_vs();
        chk("t3_cnt", 32'(frame_cnt), 3);
        wait_req(1);
        n = 1;
        while (upd_req[1] && n < 100) begin
            tick();
            if (upd_req[1]) n++;
        end
        chk("t3_req1_cycles", 32'(n), TO);
        chk("t3_overrun", 32'(overrun), 1);
        chk("t3_timeout_id", 32'(timeout_id), 1);
        wait_req(3);
        wait_idle();
        chk("t3_all_served", 32'(exp_order.size()), 0);
        chk("t3_timeout_id_kept", 32'(timeout_id), 1);
        clear_ovr();
        chk("t3_ovr_cleared", 32'(overrun), 0);
        lat[1] = 2;

        // 4: active video while waiting on client 0
        en_mask = 4'b0001; lat[0] = 6;
        rdn = 1'b0;
        repeat (2) tick();
        rdn = 1'b1;
        chk("t4_rdn_idle_no_ovr", 32'(overrun), 0);
        exp_order.push_back(0);
        pulse_vs();
        wait_req(0);
        tick();
        rdn = 1'b0;
        tick();
        rdn = 1'b1;
        chk("t4_ovr_rdn", 32'(overrun), 1);
        chk("t4_still_req0", 32'(upd_req), 32'h1);
        wait_idle();
        chk("t4_served", 32'(exp_order.size()), 0);
        clear_ovr();
        chk("t4_ovr_clr", 32'(overrun), 0);
        exp_order.push_back(0);
        pulse_vs();
        chk("t4_cnt", 32'(frame_cnt), 5);
        wait_req(0);
        rdn = 1'b0; ovr_clr = 1'b1;
        tick();
        rdn = 1'b1; ovr_clr = 1'b0;
        chk("t4_set_beats_clr", 32'(overrun), 1);
        wait_idle();
        clear_ovr();
        chk("t4_ovr_clr2", 32'(overrun), 0);

        // 5: second frame while busy on client 0; 1 and 2 join
        en_mask = 4'b0001; lat[0] = 8;
        exp_order.push_back(0); exp_order.push_back(1); exp_order.push_back(2);
        pulse_vs();
        wait_req(0);
        en_mask = 4'b0110;
        pulse_vs();
        chk("t5_tick", 32'(frame_tick), 1);
        chk("t5_cnt", 32'(frame_cnt), 7);
        chk("t5_overrun", 32'(overrun), 1);
        chk("t5_req0_continues", 32'(upd_req), 32'h1);
        wait_idle();
        chk("t5_all_served", 32'(exp_order.size()), 0);
        clear_ovr();
        lat[0] = 2;

        // 6: reset while client 2 is requested
        en_mask = 4'b0100; lat[2] = 0;
        exp_order.push_back(2);
        pulse_vs();
        chk("t6_cnt", 32'(frame_cnt), 8);
        wait_req(2);
        chk("t6_req2", 32'(upd_req), 32'h4);
        rst = 1'b1;
        tick();
        chk("t6_rst_req", 32'(upd_req), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_cnt", 32'(frame_cnt), 0);
        chk("t6_rst_overrun", 32'(overrun), 0);
        rst = 1'b0; lat[2] = 2;
        en_mask = 4'b0000;
        repeat (2) tick();
        pulse_vs();
        chk("t6_post_cnt", 32'(frame_cnt), 1);
        repeat (3) begin
            tick();
            chk("t6_pend_cleared", 32'(busy), 0);
        end
        chk("end_queue_empty", 32'(exp_order.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
